// File: rtl/mul32_seq_unit_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg -- shared definitions for the sequential 32x32 multiply unit.
//   XLEN / HALF      : operand width and partial-product operand width
//   MUL_OP_*         : op encoding (MUL, MULH, MULHSU, MULHU)
//   state_e          : multiply FSM states
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned HALF = XLEN / 2;

    localparam logic [1:0] MUL_OP_MUL    = 2'd0;
    localparam logic [1:0] MUL_OP_MULH   = 2'd1;
    localparam logic [1:0] MUL_OP_MULHSU = 2'd2;
    localparam logic [1:0] MUL_OP_MULHU  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PP0  = 3'd1,
        ST_PP1  = 3'd2,
        ST_PP2  = 3'd3,
        ST_PP3  = 3'd4,
        ST_FIX  = 3'd5
    } state_e;

endpackage

// File: rtl/mul32_seq_unit_if.sv
// ---------------------------------------------------------------------------
// mul32_seq_unit_if -- execute-stage <-> multiply unit handshake bundle.
//   start  : request, sampled only while the unit is idle
//   op     : MUL / MULH / MULHSU / MULHU
//   rs1    : multiplicand a
//   rs2    : multiplier b
//   flush  : abort any in-flight operation
//   busy   : operation in progress
//   done   : one-cycle pulse, result valid
//   result : selected product word, held until the next done
// Modports: master = execute stage, slave = multiply unit.
// ---------------------------------------------------------------------------
interface mul32_seq_unit_if;
    import mul_pkg::*;

    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, op, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, op, rs1, rs2, flush,
        output busy, done, result
    );

endinterface

// File: rtl/mul32_seq_unit_mult16.sv
// ---------------------------------------------------------------------------
// Multiplier16x16 -- combinational unsigned 16x16 -> 32 multiplier.
//   a_i : 16-bit operand
//   b_i : 16-bit operand
//   p_o : 32-bit product
// Built from four 8x8 sub-products (Vedic vertical/crosswise split).
// ---------------------------------------------------------------------------
module Multiplier16x16
    import mul_pkg::*;
(
    input  logic [HALF-1:0]   a_i,
    input  logic [HALF-1:0]   b_i,
    output logic [2*HALF-1:0] p_o
);

    logic [15:0] ll;
    logic [15:0] lh;
    logic [15:0] hl;
    logic [15:0] hh;

    always_comb begin
        ll  = {8'h00, a_i[7:0]}  * {8'h00, b_i[7:0]};
        lh  = {8'h00, a_i[7:0]}  * {8'h00, b_i[15:8]};
        hl  = {8'h00, a_i[15:8]} * {8'h00, b_i[7:0]};
        hh  = {8'h00, a_i[15:8]} * {8'h00, b_i[15:8]};
        p_o = {16'h0000, ll}
            + {8'h00, lh, 8'h00}
            + {8'h00, hl, 8'h00}
            + {hh, 16'h0000};
    end

endmodule

// File: rtl/mul32_seq_unit.sv
// ---------------------------------------------------------------------------
// mul32_seq_unit -- sequential 32x32 multiply for RV32 M-extension.
// Feeds four 16x16 partial products through one Multiplier16x16 over
// PP0..PP3, accumulates into a 64-bit magnitude, applies the sign in FIX
// and returns the low (MUL) or high (MULH/MULHSU/MULHU) word.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mul32_seq_unit_if.slave (start/op/rs1/rs2/flush in,
//           busy/done/result out)
// Optional feature: MUL_ZERO_BYPASS_EN -- a zero operand at acceptance
// skips PP0..PP3 and goes straight to FIX with a zero accumulator.
// ---------------------------------------------------------------------------
module mul32_seq_unit
    import mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    mul32_seq_unit_if.slave  bus
);

    state_e            state_q, state_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic              neg_q, neg_d;
    logic [1:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              done_q, done_d;

    logic              a_sgn, b_sgn;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [HALF-1:0]   pp_a, pp_b;
    logic [XLEN-1:0]   pp;
    logic [2*XLEN-1:0] fix_p;

    // Operand signedness: a signed for MULH/MULHSU, b signed for MULH only.
    // 0x80000000 negates to itself, which is the exact unsigned magnitude.
    always_comb begin
        a_sgn = ((bus.op == MUL_OP_MULH) || (bus.op == MUL_OP_MULHSU)) && bus.rs1[XLEN-1];
        b_sgn = (bus.op == MUL_OP_MULH) && bus.rs2[XLEN-1];
        a_mag = a_sgn ? (~bus.rs1 + XLEN'(1)) : bus.rs1;
        b_mag = b_sgn ? (~bus.rs2 + XLEN'(1)) : bus.rs2;
    end

    // Partial-product operand select follows the current state.
    always_comb begin
        pp_a = '0;
        pp_b = '0;
        unique case (state_q)
            ST_PP0: begin pp_a = a_q[HALF-1:0];    pp_b = b_q[HALF-1:0];    end
            ST_PP1: begin pp_a = a_q[XLEN-1:HALF]; pp_b = b_q[HALF-1:0];    end
            ST_PP2: begin pp_a = a_q[HALF-1:0];    pp_b = b_q[XLEN-1:HALF]; end
            ST_PP3: begin pp_a = a_q[XLEN-1:HALF]; pp_b = b_q[XLEN-1:HALF]; end
            default: ;
        endcase
    end

    Multiplier16x16 u_mult16 (
        .a_i (pp_a),
        .b_i (pp_b),
        .p_o (pp)
    );

    always_comb begin
        fix_p = neg_q ? (~acc_q + (2*XLEN)'(1)) : acc_q;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        op_d     = op_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (bus.flush) begin
            state_d = ST_IDLE;
            acc_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_d     = a_mag;
                        b_d     = b_mag;
                        op_d    = bus.op;
                        neg_d   = a_sgn ^ b_sgn;
                        state_d = ST_PP0;
`ifdef MUL_ZERO_BYPASS_EN
                        if ((bus.rs1 == '0) || (bus.rs2 == '0)) begin
                            acc_d   = '0;
                            neg_d   = 1'b0;
                            state_d = ST_FIX;
                        end
`endif
                    end
                end
                ST_PP0: begin
                    acc_d   = {{XLEN{1'b0}}, pp};
                    state_d = ST_PP1;
                end
                ST_PP1: begin
                    acc_d   = acc_q + {{HALF{1'b0}}, pp, {HALF{1'b0}}};
                    state_d = ST_PP2;
                end
                ST_PP2: begin
                    acc_d   = acc_q + {{HALF{1'b0}}, pp, {HALF{1'b0}}};
                    state_d = ST_PP3;
                end
                ST_PP3: begin
                    acc_d   = acc_q + {pp, {XLEN{1'b0}}};
                    state_d = ST_FIX;
                end
                ST_FIX: begin
                    result_d = (op_q == MUL_OP_MUL) ? fix_p[XLEN-1:0] : fix_p[2*XLEN-1:XLEN];
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            op_q     <= MUL_OP_MUL;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;

endmodule

// File: tb/tb_mul32_seq_unit.sv
// ---------------------------------------------------------------------------
// tb_mul32_seq_unit -- self-checking bench for mul32_seq_unit.
// Directed cases followed by random operations, each compared against a
// 64-bit arithmetic reference of the RV32 multiply semantics.
// ---------------------------------------------------------------------------
module tb_mul32_seq_unit;
    import mul_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] last_res;

    mul32_seq_unit_if bus ();

    mul32_seq_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: extend each operand to 64 bits per its signedness; the
    // low 64 bits of the product are exact for every RV32 multiply variant.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (op == 2'd1 || op == 2'd2) ? {{32{a[31]}}, a} : {32'h0, a};
        be = (op == 2'd1) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ae * be;
        return (op == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    function automatic int exp_latency(input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_ZERO_BYPASS_EN
        return (a == 32'h0 || b == 32'h0) ? 1 : 5;
`else
        return 5;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge; leaves the bench in the done cycle
    // so the next call issues back-to-back.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        int lat;
        int exp_lat;
        logic [31:0] exp_res;
        exp_lat = exp_latency(a, b);
        exp_res = ref_mul(op, a, b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs1   = a;
        bus.rs2   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.op    = $urandom_range(0, 3);
        bus.rs1   = $urandom;
        bus.rs2   = $urandom;
        check({tag, "_busy_accept"}, 64'(bus.busy), 64'(1));
        check({tag, "_done_low"}, 64'(bus.done), 64'(0));
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) begin
                lat = n;
                break;
            end
            if (bus.busy !== 1'b1) check({tag, "_busy_hold"}, 64'(bus.busy), 64'(1));
        end
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
        check({tag, "_result"}, 64'(bus.result), 64'(exp_res));
        last_res = exp_res;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        checks    = 0;
        errors    = 0;
        last_res  = 32'h0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.rs1   = 32'h0;
        bus.rs2   = 32'h0;
        bus.flush = 1'b0;
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mul_7x6", MUL_OP_MUL, 32'd7, 32'd6);
        do_op("mulhu_ff", MUL_OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mul_ff", MUL_OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulh_min", MUL_OP_MULH, 32'h8000_0000, 32'h8000_0000);
        do_op("mulh_m1", MUL_OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mulhsu_m1", MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("direct_mulhsu_val", 64'(bus.result), 64'(32'hFFFF_FFFF));

        // Flush while in PP2: no done, unit idle next cycle, result kept.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MUL_OP_MUL; bus.rs1 = 32'd1000; bus.rs2 = 32'd1000;
        @(posedge clk); #1;          // PP0
        bus.start = 1'b0;
        @(posedge clk); #1;          // PP1
        @(posedge clk); #1;          // PP2
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'(0));
        check("flush_done", 64'(bus.done), 64'(0));
        check("flush_result", 64'(bus.result), 64'(last_res));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0) check("flush_no_done", 64'(bus.done), 64'(0));
        end
        // Start together with flush in IDLE is rejected.
        bus.start = 1'b1; bus.flush = 1'b1; bus.rs1 = 32'd9; bus.rs2 = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        check("flush_start_rej", 64'(bus.busy), 64'(0));
        do_op("mul_3x5", MUL_OP_MUL, 32'd3, 32'd5);

        // Asynchronous reset while in PP1.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = MUL_OP_MULHU; bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'h1234_5678;
        @(posedge clk); #1;          // PP0
        bus.start = 1'b0;
        @(posedge clk); #1;          // PP1
        rst_n = 1'b0;
        #1;
        check("arst_busy", 64'(bus.busy), 64'(0));
        check("arst_done", 64'(bus.done), 64'(0));
        check("arst_result", 64'(bus.result), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_res = 32'h0;
        @(posedge clk); #1;

        do_op("mulh_zero", MUL_OP_MULH, 32'h0, 32'h1234_5678);
        do_op("mulhsu_zero", MUL_OP_MULHSU, 32'h8000_0000, 32'h0);

        for (int k = 0; k < 40; k++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h0;
                1: rb = 32'h0;
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            do_op("rand", rop, ra, rb);
        end

        @(posedge clk); #1;
        check("done_pulse_end", 64'(bus.done), 64'(0));
        check("result_hold_end", 64'(bus.result), 64'(last_res));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
